display_scan_ctrl: RTL

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 4-digit display scanner with a frame-aligned message override.
// A primary value is shown by default; an alternate requester can borrow the display for HOLD_FRAMES frames.
module display_scan_ctrl #(
  parameter int CLK_DIV     = 50000,
  parameter int BLANK_CYC   = 500,
  parameter int HOLD_FRAMES = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] base_val,
  input  logic [15:0] msg_val,
  input  logic        msg_req,
  input  logic [3:0]  digit_en,
  output logic        msg_ack,
  output logic        msg_busy,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        frame_tick,
  output logic        o_dbg_state
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  typedef enum logic {ST_BASE = 1'b0, ST_MSG = 1'b1} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_pcnt;
  logic [1:0]      r_idx;
  logic [HW-1:0]   r_hold;
  logic [15:0]     r_base_snap;
  logic [15:0]     r_msg_snap;

  logic            w_slot_end;
  logic            w_frame_end;
  logic            w_active;
  logic [15:0]     w_snap;

  assign w_slot_end  = (r_pcnt == PW'(CLK_DIV - 1));
  assign w_frame_end = w_slot_end && (r_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_BASE;
      r_pcnt      <= '0;
      r_idx       <= 2'd0;
      r_hold      <= '0;
      r_base_snap <= 16'h0000;
      r_msg_snap  <= 16'h0000;
    end else begin
      r_pcnt <= w_slot_end ? '0 : r_pcnt + 1'b1;
      if (w_slot_end) begin
        r_idx <= r_idx + 2'd1;
      end
      // All content and ownership changes happen only on frame boundaries.
      if (w_frame_end) begin
        r_base_snap <= base_val;
        case (r_state)
          ST_BASE: begin
            if (msg_req) begin
              r_msg_snap <= msg_val;
              r_hold     <= HW'(HOLD_FRAMES);
              r_state    <= ST_MSG;
            end
          end
          ST_MSG: begin
            if (r_hold == HW'(1)) begin
              r_hold  <= '0;
              r_state <= ST_BASE;
            end else begin
              r_hold <= r_hold - 1'b1;
            end
          end
          default: r_state <= ST_BASE;
        endcase
      end
    end
  end

  // Outputs are gated by rst so they are idle from the first reset cycle.
  assign w_active    = rst && (r_pcnt >= PW'(BLANK_CYC)) && digit_en[r_idx];
  assign w_snap      = (r_state == ST_MSG) ? r_msg_snap : r_base_snap;
  assign an          = w_active ? ~(4'b0001 << r_idx) : 4'b1111;
  assign digit       = w_active ? w_snap[r_idx*4 +: 4] : 4'h0;
  assign msg_ack     = rst && (r_state == ST_BASE) && msg_req && w_frame_end;
  assign msg_busy    = rst && (r_state == ST_MSG);
  assign frame_tick  = rst && w_frame_end;
  assign o_dbg_state = r_state;

endmodule
